// File: rtl/seq_stage_ctrl_if.sv
// Bus between the sequential stage controller and its datapath/memory.
// The slave modport is the controller's view; master is the datapath side.
interface seq_stage_ctrl_if;
    // datapath/memory -> controller
    logic        start;
    logic [3:0]  icode;
    logic        memory_error;
    logic        invalid_instr;
    logic        halt;
    logic        cnd;
    logic [63:0] valC;
    logic [63:0] valP;
    logic [63:0] valM;
    logic        mem_ack;
    logic        mem_err;

    // controller -> datapath/memory
    logic [63:0] PC;
    logic        fetch_en;
    logic        decode_en;
    logic        exec_en;
    logic        wb_en;
    logic        mem_req;
    logic [2:0]  state;
    logic [2:0]  stat;
    logic [31:0] instr_cnt;
    logic        busy;

    modport master (
        output start, icode, memory_error, invalid_instr, halt, cnd,
               valC, valP, valM, mem_ack, mem_err,
        input  PC, fetch_en, decode_en, exec_en, wb_en, mem_req,
               state, stat, instr_cnt, busy
    );

    modport slave (
        input  start, icode, memory_error, invalid_instr, halt, cnd,
               valC, valP, valM, mem_ack, mem_err,
        output PC, fetch_en, decode_en, exec_en, wb_en, mem_req,
               state, stat, instr_cnt, busy
    );
endinterface

// File: rtl/seq_stage_ctrl.sv
// Sequential (non-pipelined) Y86-style stage controller.
// Walks one instruction at a time through FETCH, DECODE, EXECUTE, optional
// MEMORY, WRITEBACK and PCUPD; faults and halts park the machine in HALTED
// with the program counter left at the offending instruction.
module seq_stage_ctrl (
    input  logic               clk,
    input  logic               rst,
    seq_stage_ctrl_if.slave    bus
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEMORY    = 3'd4,
        S_WRITEBACK = 3'd5,
        S_PCUPD     = 3'd6,
        S_HALTED    = 3'd7
    } state_t;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    localparam logic [3:0] IC_HALT = 4'h0;
    localparam logic [3:0] IC_JXX  = 4'h7;
    localparam logic [3:0] IC_CALL = 4'h8;
    localparam logic [3:0] IC_RET  = 4'h9;

    // Instructions that touch data memory: rmmovq, mrmovq, call, ret, push, pop.
    function automatic logic is_mem_icode(input logic [3:0] ic);
        logic res;
        case (ic)
            4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB: res = 1'b1;
            default:                            res = 1'b0;
        endcase
        return res;
    endfunction

    // New PC: call and taken jumps go to valC, ret to the popped address,
    // everything else falls through to the next sequential address.
    function automatic logic [63:0] pc_select(
        input logic [3:0]  ic,
        input logic        taken,
        input logic [63:0] val_c,
        input logic [63:0] val_p,
        input logic [63:0] val_m
    );
        logic [63:0] res;
        if (ic == IC_CALL) begin
            res = val_c;
        end else if ((ic == IC_JXX) && taken) begin
            res = val_c;
        end else if (ic == IC_RET) begin
            res = val_m;
        end else begin
            res = val_p;
        end
        return res;
    endfunction

    // Registered state and outputs
    state_t      r_state;
    logic [63:0] r_pc;
    logic [2:0]  r_stat;
    logic [31:0] r_instr_cnt;
    logic        r_cnd;
    logic [3:0]  r_icode;
    logic        r_fetch_en;
    logic        r_decode_en;
    logic        r_exec_en;
    logic        r_wb_en;
    logic        r_mem_req;
    logic        r_busy;

    // Next-state values
    state_t      w_state_nxt;
    logic [63:0] w_pc_nxt;
    logic [2:0]  w_stat_nxt;
    logic [31:0] w_instr_cnt_nxt;
    logic        w_is_mem;

    // The icode captured at the end of FETCH steers the rest of the instruction.
    assign w_is_mem = is_mem_icode(r_icode);

    // Next-state, status, PC and retire-count decisions for the current state.
    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_stat_nxt      = r_stat;
        w_instr_cnt_nxt = r_instr_cnt;

        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = S_FETCH;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end

            S_FETCH: begin
                // Fault priority: address error, illegal code, then halt.
                if (bus.memory_error) begin
                    w_state_nxt = S_HALTED;
                    w_stat_nxt  = STAT_ADR;
                end else if (bus.invalid_instr) begin
                    w_state_nxt = S_HALTED;
                    w_stat_nxt  = STAT_INS;
                end else if (bus.halt || (bus.icode == IC_HALT)) begin
                    w_state_nxt = S_HALTED;
                    w_stat_nxt  = STAT_HLT;
                end else begin
                    w_state_nxt = S_DECODE;
                end
            end

            S_DECODE: begin
                w_state_nxt = S_EXECUTE;
            end

            S_EXECUTE: begin
                if (w_is_mem) begin
                    w_state_nxt = S_MEMORY;
                end else begin
                    w_state_nxt = S_WRITEBACK;
                end
            end

            S_MEMORY: begin
                // No timeout: the request stays up until memory answers.
                if (bus.mem_ack) begin
                    if (bus.mem_err) begin
                        w_state_nxt = S_HALTED;
                        w_stat_nxt  = STAT_ADR;
                    end else begin
                        w_state_nxt = S_WRITEBACK;
                    end
                end else begin
                    w_state_nxt = S_MEMORY;
                end
            end

            S_WRITEBACK: begin
                w_state_nxt = S_PCUPD;
            end

            S_PCUPD: begin
                // Only a fully completed instruction retires and moves the PC.
                w_state_nxt     = S_FETCH;
                w_pc_nxt        = pc_select(r_icode, r_cnd, bus.valC, bus.valP, bus.valM);
                w_instr_cnt_nxt = r_instr_cnt + 32'd1;
            end

            S_HALTED: begin
                w_state_nxt = S_HALTED;
            end

            default: begin
                // Unreachable encoding: park safely rather than run on.
                w_state_nxt = S_HALTED;
                w_stat_nxt  = STAT_INS;
            end
        endcase
    end

    // State, architectural registers and decoded outputs, with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_pc        <= 64'd0;
            r_stat      <= STAT_AOK;
            r_instr_cnt <= 32'd0;
            r_cnd       <= 1'b0;
            r_icode     <= 4'd0;
            r_fetch_en  <= 1'b0;
            r_decode_en <= 1'b0;
            r_exec_en   <= 1'b0;
            r_wb_en     <= 1'b0;
            r_mem_req   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_stat      <= w_stat_nxt;
            r_instr_cnt <= w_instr_cnt_nxt;
            // Branch outcome is only meaningful at the end of EXECUTE.
            r_cnd       <= (r_state == S_EXECUTE) ? bus.cnd : r_cnd;
            r_icode     <= (r_state == S_FETCH) ? bus.icode : r_icode;
            // Outputs are decoded from the next state so they line up with r_state.
            r_fetch_en  <= (w_state_nxt == S_FETCH);
            r_decode_en <= (w_state_nxt == S_DECODE);
            r_exec_en   <= (w_state_nxt == S_EXECUTE);
            r_wb_en     <= (w_state_nxt == S_WRITEBACK);
            r_mem_req   <= (w_state_nxt == S_MEMORY);
            r_busy      <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_HALTED);
        end
    end

    assign bus.PC        = r_pc;
    assign bus.state     = r_state;
    assign bus.stat      = r_stat;
    assign bus.instr_cnt = r_instr_cnt;
    assign bus.fetch_en  = r_fetch_en;
    assign bus.decode_en = r_decode_en;
    assign bus.exec_en   = r_exec_en;
    assign bus.wb_en     = r_wb_en;
    assign bus.mem_req   = r_mem_req;
    assign bus.busy      = r_busy;

endmodule

// File: tb/tb_seq_stage_ctrl.sv
// Self-checking bench for seq_stage_ctrl: a reference model predicts each
// instruction's outcome into a scoreboard, and the entry is popped and
// compared when the controller retires or halts.
module tb_seq_stage_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;

    seq_stage_ctrl_if bus ();

    seq_stage_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] cnt;
        logic [2:0]  stat;
        logic [2:0]  st;
        int          cyc;
        int          mreq;
        logic [7:0]  path;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] m_pc;
    logic [31:0] m_cnt;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.start         = 1'b0;
        bus.icode         = 4'h1;
        bus.memory_error  = 1'b0;
        bus.invalid_instr = 1'b0;
        bus.halt          = 1'b0;
        bus.cnd           = 1'b0;
        bus.valC          = 64'd0;
        bus.valP          = 64'd0;
        bus.valM          = 64'd0;
        bus.mem_ack       = 1'b0;
        bus.mem_err       = 1'b0;
    endtask

    task automatic do_reset;
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_pc  = 64'd0;
        m_cnt = 32'd0;
    endtask

    task automatic do_start;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // Reference model: expected result of one instruction started from FETCH.
    task automatic predict(input logic [3:0] ic, input logic me, input logic ii,
                           input logic hl, input logic c, input logic [63:0] vc,
                           input logic [63:0] vp, input logic [63:0] vm,
                           input int dly, input logic merr);
        exp_t e;
        logic is_mem;
        is_mem = (ic == 4'h4) || (ic == 4'h5) || (ic == 4'h8) ||
                 (ic == 4'h9) || (ic == 4'hA) || (ic == 4'hB);
        e.mreq = 0;
        if (me || ii || hl || (ic == 4'h0)) begin
            e.stat = me ? 3'd3 : (ii ? 3'd4 : 3'd2);
            e.st   = 3'd7;
            e.cyc  = 1;
            e.path = 8'h02;
        end else if (is_mem && merr) begin
            e.stat = 3'd3;
            e.st   = 3'd7;
            e.cyc  = 4 + dly;
            e.mreq = dly + 1;
            e.path = 8'h1E;
        end else begin
            e.stat = 3'd1;
            e.st   = 3'd1;
            e.cyc  = is_mem ? 6 + dly : 5;
            e.mreq = is_mem ? dly + 1 : 0;
            e.path = is_mem ? 8'h7E : 8'h6E;
            if (ic == 4'h8)                m_pc = vc;
            else if ((ic == 4'h7) && c)    m_pc = vc;
            else if (ic == 4'h9)           m_pc = vm;
            else                           m_pc = vp;
            m_cnt = m_cnt + 32'd1;
        end
        e.pc  = m_pc;
        e.cnt = m_cnt;
        sb.push_back(e);
    endtask

    // Drives one instruction from FETCH until it retires or halts. Inputs
    // that are don't-care in a given state carry misleading values.
    task automatic run_instr(input logic [3:0] ic, input logic me, input logic ii,
                             input logic hl, input logic c, input logic [63:0] vc,
                             input logic [63:0] vp, input logic [63:0] vm,
                             input int dly, input logic merr,
                             output int cyc, output int mreq,
                             output logic [7:0] path, output int enerr);
        int w;
        logic [2:0] s;
        cyc = 0; mreq = 0; path = 8'h00; enerr = 0; w = 0;
        bus.icode = ic;
        bus.valC  = vc;
        bus.valP  = vp;
        bus.valM  = vm;
        do begin
            s = bus.state;
            bus.start         = 1'b1;
            bus.memory_error  = (s == 3'd1) ? me : 1'b1;
            bus.invalid_instr = (s == 3'd1) ? ii : 1'b1;
            bus.halt          = (s == 3'd1) ? hl : 1'b1;
            bus.cnd           = (s == 3'd3) ? c : ~c;
            if (s == 3'd4) begin
                bus.mem_ack = (w == dly);
                bus.mem_err = (w == dly) ? merr : 1'b1;
                w++;
            end else begin
                bus.mem_ack = 1'b1;
                bus.mem_err = 1'b0;
            end
            if (bus.mem_req === 1'b1) mreq++;
            if (bus.fetch_en !== (s == 3'd1) || bus.decode_en !== (s == 3'd2) ||
                bus.exec_en !== (s == 3'd3) || bus.wb_en !== (s == 3'd5) ||
                bus.mem_req !== (s == 3'd4) || bus.busy !== ((s != 3'd0) && (s != 3'd7)))
                enerr++;
            path[s] = 1'b1;
            tick();
            cyc++;
        end while (!(bus.state inside {3'd0, 3'd1, 3'd7}) && (cyc < 60));
        idle_inputs();
    endtask

    task automatic test_reset;
        do_reset();
        n_checks++;
        if ({bus.state, bus.PC, bus.stat, bus.instr_cnt} !== {3'd0, 64'd0, 3'd1, 32'd0}) begin
            n_errors++;
            $display("FAIL reset_arch: state=%0d pc=%h stat=%0d cnt=%h expected 0/0/1/0",
                     bus.state, bus.PC, bus.stat, bus.instr_cnt);
        end
        n_checks++;
        if ({bus.fetch_en, bus.decode_en, bus.exec_en, bus.wb_en, bus.mem_req, bus.busy} !== 6'b000000) begin
            n_errors++;
            $display("FAIL reset_outs: en/req/busy=%b expected 000000",
                     {bus.fetch_en, bus.decode_en, bus.exec_en, bus.wb_en, bus.mem_req, bus.busy});
        end
        bus.mem_ack = 1'b1;
        tick();
        tick();
        bus.mem_ack = 1'b0;
        n_checks++;
        if (bus.state !== 3'd0) begin
            n_errors++;
            $display("FAIL idle_hold: state=%0d expected 0", bus.state);
        end
        do_start();
        n_checks++;
        if ({bus.state, bus.fetch_en, bus.busy} !== {3'd1, 1'b1, 1'b1}) begin
            n_errors++;
            $display("FAIL start: state=%0d fetch_en=%b busy=%b expected 1/1/1",
                     bus.state, bus.fetch_en, bus.busy);
        end
    endtask

    // nop, taken and not-taken jumps (controller left in FETCH by test_reset)
    task automatic test_nop_branch;
        logic [3:0]  t_ic[3] = '{4'h1, 4'h7, 4'h7};
        logic        t_c[3]  = '{1'b0, 1'b1, 1'b0};
        logic [63:0] t_vc[3] = '{64'h77, 64'h40, 64'h80};
        logic [63:0] t_vp[3] = '{64'h1, 64'h3, 64'h9};
        int cyc, mreq, enerr;
        logic [7:0] path;
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            predict(t_ic[i], 1'b0, 1'b0, 1'b0, t_c[i], t_vc[i], t_vp[i], 64'hDEAD, 0, 1'b0);
            run_instr(t_ic[i], 1'b0, 1'b0, 1'b0, t_c[i], t_vc[i], t_vp[i], 64'hDEAD, 0, 1'b0,
                      cyc, mreq, path, enerr);
            e = sb.pop_front();
            n_checks++;
            if ({bus.PC, bus.instr_cnt, bus.stat, bus.state} !== {e.pc, e.cnt, e.stat, e.st}) begin
                n_errors++;
                $display("FAIL nop_branch[%0d] arch: pc=%h cnt=%0d stat=%0d state=%0d expected pc=%h cnt=%0d stat=%0d state=%0d",
                         i, bus.PC, bus.instr_cnt, bus.stat, bus.state, e.pc, e.cnt, e.stat, e.st);
            end
            n_checks++;
            if (cyc !== e.cyc || mreq !== e.mreq || path !== e.path || enerr !== 0) begin
                n_errors++;
                $display("FAIL nop_branch[%0d] timing: cyc=%0d mreq=%0d path=%h enerr=%0d expected %0d/%0d/%h/0",
                         i, cyc, mreq, path, enerr, e.cyc, e.mreq, e.path);
            end
        end
    endtask

    // memory instructions with varying acknowledge latency
    task automatic test_mem;
        logic [3:0]  t_ic[4]  = '{4'h5, 4'h8, 4'h9, 4'h4};
        int          t_dly[4] = '{3, 0, 1, 2};
        int cyc, mreq, enerr;
        logic [7:0] path;
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            predict(t_ic[i], 1'b0, 1'b0, 1'b0, 1'b1, 64'h1000 + 64'(i), 64'h2000 + 64'(i),
                    64'h3000 + 64'(i), t_dly[i], 1'b0);
            run_instr(t_ic[i], 1'b0, 1'b0, 1'b0, 1'b1, 64'h1000 + 64'(i), 64'h2000 + 64'(i),
                      64'h3000 + 64'(i), t_dly[i], 1'b0, cyc, mreq, path, enerr);
            e = sb.pop_front();
            n_checks++;
            if ({bus.PC, bus.instr_cnt, bus.stat, bus.state} !== {e.pc, e.cnt, e.stat, e.st}) begin
                n_errors++;
                $display("FAIL mem[%0d] arch: pc=%h cnt=%0d stat=%0d state=%0d expected pc=%h cnt=%0d stat=%0d state=%0d",
                         i, bus.PC, bus.instr_cnt, bus.stat, bus.state, e.pc, e.cnt, e.stat, e.st);
            end
            n_checks++;
            if (cyc !== e.cyc || mreq !== e.mreq || path !== e.path || enerr !== 0) begin
                n_errors++;
                $display("FAIL mem[%0d] timing: cyc=%0d mreq=%0d path=%h enerr=%0d expected %0d/%0d/%h/0",
                         i, cyc, mreq, path, enerr, e.cyc, e.mreq, e.path);
            end
        end
    endtask

    // random non-faulting instructions issued back to back
    task automatic test_back_to_back;
        logic [3:0] pool[11] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB};
        logic [3:0] ic;
        logic c;
        logic [63:0] vc, vp, vm;
        int dly, cyc, mreq, enerr;
        logic [7:0] path;
        exp_t e;
        for (int i = 0; i < 12; i++) begin
            ic  = pool[$urandom_range(0, 10)];
            c   = 1'($urandom_range(0, 1));
            vc  = {$urandom, $urandom};
            vp  = {$urandom, $urandom};
            vm  = {$urandom, $urandom};
            dly = $urandom_range(0, 2);
            predict(ic, 1'b0, 1'b0, 1'b0, c, vc, vp, vm, dly, 1'b0);
            run_instr(ic, 1'b0, 1'b0, 1'b0, c, vc, vp, vm, dly, 1'b0, cyc, mreq, path, enerr);
            e = sb.pop_front();
            n_checks++;
            if ({bus.PC, bus.instr_cnt, bus.stat, bus.state} !== {e.pc, e.cnt, e.stat, e.st} ||
                cyc !== e.cyc || mreq !== e.mreq || path !== e.path || enerr !== 0) begin
                n_errors++;
                $display("FAIL b2b[%0d] ic=%h: pc=%h cnt=%0d stat=%0d cyc=%0d mreq=%0d path=%h enerr=%0d expected pc=%h cnt=%0d stat=%0d cyc=%0d mreq=%0d path=%h",
                         i, ic, bus.PC, bus.instr_cnt, bus.stat, cyc, mreq, path, enerr,
                         e.pc, e.cnt, e.stat, e.cyc, e.mreq, e.path);
            end
        end
    endtask

    // fetch faults, halt, data-memory error; HALTED absorbs until reset
    task automatic test_halts;
        logic       h_me[5]   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic       h_ii[5]   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic       h_hl[5]   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [3:0] h_ic[5]   = '{4'h1, 4'h1, 4'h1, 4'h0, 4'hA};
        logic       h_merr[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        int cyc, mreq, enerr;
        logic [7:0] path;
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            do_reset();
            do_start();
            predict(4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h123, 64'h0, 0, 1'b0);
            run_instr(4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h123, 64'h0, 0, 1'b0,
                      cyc, mreq, path, enerr);
            e = sb.pop_front();
            n_checks++;
            if ({bus.PC, bus.instr_cnt, bus.state} !== {e.pc, e.cnt, e.st}) begin
                n_errors++;
                $display("FAIL halt[%0d] setup: pc=%h cnt=%0d state=%0d expected pc=%h cnt=%0d state=%0d",
                         i, bus.PC, bus.instr_cnt, bus.state, e.pc, e.cnt, e.st);
            end
            predict(h_ic[i], h_me[i], h_ii[i], h_hl[i], 1'b0, 64'h55, 64'h66, 64'h77, 0, h_merr[i]);
            run_instr(h_ic[i], h_me[i], h_ii[i], h_hl[i], 1'b0, 64'h55, 64'h66, 64'h77, 0, h_merr[i],
                      cyc, mreq, path, enerr);
            e = sb.pop_front();
            n_checks++;
            if ({bus.PC, bus.instr_cnt, bus.stat, bus.state} !== {e.pc, e.cnt, e.stat, e.st} ||
                cyc !== e.cyc || mreq !== e.mreq || path !== e.path || enerr !== 0) begin
                n_errors++;
                $display("FAIL halt[%0d] fault: pc=%h cnt=%0d stat=%0d state=%0d cyc=%0d path=%h enerr=%0d expected pc=%h cnt=%0d stat=%0d state=%0d cyc=%0d path=%h",
                         i, bus.PC, bus.instr_cnt, bus.stat, bus.state, cyc, path, enerr,
                         e.pc, e.cnt, e.stat, e.st, e.cyc, e.path);
            end
            bus.start   = 1'b1;
            bus.mem_ack = 1'b1;
            tick();
            tick();
            tick();
            idle_inputs();
            n_checks++;
            if ({bus.state, bus.stat, bus.PC, bus.fetch_en, bus.decode_en, bus.exec_en,
                 bus.wb_en, bus.mem_req, bus.busy} !== {3'd7, e.stat, e.pc, 6'b000000}) begin
                n_errors++;
                $display("FAIL halt[%0d] absorb: state=%0d stat=%0d pc=%h outs=%b expected 7/%0d/%h/000000",
                         i, bus.state, bus.stat, bus.PC,
                         {bus.fetch_en, bus.decode_en, bus.exec_en, bus.wb_en, bus.mem_req, bus.busy},
                         e.stat, e.pc);
            end
            do_reset();
            n_checks++;
            if ({bus.state, bus.stat, bus.PC} !== {3'd0, 3'd1, 64'd0}) begin
                n_errors++;
                $display("FAIL halt[%0d] rst: state=%0d stat=%0d pc=%h expected 0/1/0",
                         i, bus.state, bus.stat, bus.PC);
            end
        end
    endtask

    // reset in the middle of a data-memory handshake drops the request
    task automatic test_mem_reset;
        int cyc, mreq, enerr, n;
        logic [7:0] path;
        exp_t e;
        do_reset();
        do_start();
        predict(4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h55, 64'h0, 0, 1'b0);
        run_instr(4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h55, 64'h0, 0, 1'b0,
                  cyc, mreq, path, enerr);
        e = sb.pop_front();
        n_checks++;
        if ({bus.PC, bus.instr_cnt} !== {e.pc, e.cnt}) begin
            n_errors++;
            $display("FAIL mem_rst setup: pc=%h cnt=%0d expected pc=%h cnt=%0d",
                     bus.PC, bus.instr_cnt, e.pc, e.cnt);
        end
        bus.icode = 4'h5;
        n = 0;
        while ((bus.state !== 3'd4) && (n < 10)) begin
            tick();
            n++;
        end
        tick();
        n_checks++;
        if ({bus.state, bus.mem_req} !== {3'd4, 1'b1}) begin
            n_errors++;
            $display("FAIL mem_rst wait: state=%0d mem_req=%b expected 4/1", bus.state, bus.mem_req);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_pc  = 64'd0;
        m_cnt = 32'd0;
        n_checks++;
        if ({bus.state, bus.mem_req, bus.PC, bus.instr_cnt, bus.busy} !== {3'd0, 1'b0, 64'd0, 32'd0, 1'b0}) begin
            n_errors++;
            $display("FAIL mem_rst drop: state=%0d mem_req=%b pc=%h cnt=%0d busy=%b expected 0/0/0/0/0",
                     bus.state, bus.mem_req, bus.PC, bus.instr_cnt, bus.busy);
        end
        bus.mem_ack = 1'b1;
        tick();
        tick();
        tick();
        bus.mem_ack = 1'b0;
        n_checks++;
        if ({bus.state, bus.mem_req, bus.wb_en} !== {3'd0, 1'b0, 1'b0}) begin
            n_errors++;
            $display("FAIL mem_rst late_ack: state=%0d mem_req=%b wb_en=%b expected 0/0/0",
                     bus.state, bus.mem_req, bus.wb_en);
        end
    endtask

    initial begin
        idle_inputs();
        m_pc  = 64'd0;
        m_cnt = 32'd0;
        test_reset();
        test_nop_branch();
        test_mem();
        test_back_to_back();
        test_halts();
        test_mem_reset();
        n_checks++;
        if (sb.size() !== 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/seq_stage_ctrl.md
SEQ_STAGE_CTRL -- requirements
Module: seq_stage_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk (input, 1, rising-edge clock) and rst (input, 1, synchronous active-high reset).
REQ-002 start  input  1  request to begin execution from PC 0; sampled only in IDLE.
REQ-003 icode  input  4  instruction code from fetch; valid at the end of FETCH.
REQ-004 memory_error, invalid_instr, halt  input  1 each  fetch status flags; valid at the end of FETCH.
REQ-005 cnd  input  1  branch condition from execute; valid at the end of EXECUTE.
REQ-006 valC, valP, valM  input  64 each  constant, next-sequential PC and memory read value; valid in PCUPD.
REQ-007 mem_ack  input  1  data-memory completion handshake; mem_err  input  1  data-memory address error, qualified by mem_ack.
REQ-008 PC  output  64  registered program counter.
REQ-009 fetch_en, decode_en, exec_en, wb_en  output  1 each  stage enables, each high only in its own state.
REQ-010 mem_req  output  1  data-memory request, held high in MEMORY until mem_ack.
REQ-011 state  output  3  current FSM state; stat  output  3  Y86 status: AOK=1, HLT=2, ADR=3, INS=4.
REQ-012 instr_cnt  output  32  count of retired instructions; busy  output  1  high in every state except IDLE and HALTED.

Function
REQ-013 The FSM SHALL use these state encodings: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, PCUPD=6, HALTED=7.
REQ-014 IDLE SHALL move to FETCH on the first clock edge where start=1; start in any other state SHALL be ignored.
REQ-015 FETCH SHALL last 1 cycle; exit priority at its end: memory_error -> HALTED with stat=ADR; else invalid_instr -> HALTED with stat=INS; else halt or icode=0 -> HALTED with stat=HLT; else DECODE.
REQ-016 DECODE and EXECUTE SHALL last 1 cycle each and proceed in order.
REQ-017 After EXECUTE, icode in {4,5,8,9,A,B} SHALL go to MEMORY; all other icodes SHALL skip to WRITEBACK.
REQ-018 MEMORY SHALL hold mem_req=1 until mem_ack=1 (no timeout); on the ack cycle, mem_err=1 -> HALTED with stat=ADR, else WRITEBACK.
REQ-019 mem_ack received outside MEMORY SHALL be ignored.
REQ-020 WRITEBACK SHALL last 1 cycle and then go to PCUPD.
REQ-021 PCUPD SHALL last 1 cycle and load PC: icode=8 -> valC; icode=7 and cnd=1 -> valC; icode=9 -> valM; otherwise valP.
REQ-022 PCUPD SHALL increment instr_cnt by 1, wrapping from FFFFFFFF to 0, and then return to FETCH.
REQ-023 cnd SHALL be registered at the end of EXECUTE; PCUPD SHALL use the registered value.
REQ-024 An instruction that ends in HALTED SHALL NOT update PC or instr_cnt, so PC keeps the faulting or halting address.
REQ-025 HALTED SHALL be absorbing until rst; there all enables and mem_req are 0 and stat holds.
REQ-026 Non-memory instructions SHALL take exactly 5 cycles (FETCH..PCUPD); memory instructions SHALL take 6 + wait cycles.

Reset
REQ-027 rst SHALL, at the clock edge, force state=IDLE, PC=0, stat=AOK, instr_cnt=0, all enables and mem_req=0, busy=0, and the registered cnd=0.
REQ-028 rst SHALL have priority over start, mem_ack and every transition, including mid-MEMORY handshake; a pending request SHALL be dropped, not completed.

Verification
REQ-029 rst, then start, with icode=1 (nop) and valP=1 -> FETCH,DECODE,EXECUTE,WRITEBACK,PCUPD; PC=1 and instr_cnt=1 after 5 cycles; stat=1.
REQ-030 icode=7, cnd=1, valC=0x40 -> PC=0x40; repeat with cnd=0, valP=9 -> PC=9.
REQ-031 icode=5 with mem_ack delayed 3 cycles -> mem_req high for 4 cycles; 9 cycles in total; PC=valP.
REQ-032 Fetch with invalid_instr=1 and halt=1 -> HALTED, stat=4, PC unchanged; start afterwards is ignored; rst returns to IDLE with stat=1.
REQ-033 icode=A with mem_ack=1 and mem_err=1 -> stat=3, HALTED, instr_cnt unchanged.
REQ-034 rst asserted in MEMORY while mem_req=1 -> next cycle state=0, mem_req=0, PC=0; a late mem_ack is ignored.
